// File: rtl/timer_a_periph_pkg.sv
// Shared definitions for the Timer_A-style peripheral: register offsets,
// mode-control encodings, bit positions and small helper functions.
package timer_a_periph_pkg;

  // Register offsets relative to the peripheral base address (word aligned)
  localparam logic [15:0] OFF_TACTL   = 16'h0000;
  localparam logic [15:0] OFF_TACCTL0 = 16'h0002;
  localparam logic [15:0] OFF_TAR     = 16'h0010;
  localparam logic [15:0] OFF_TACCR0  = 16'h0012;

  // TACTL bit positions
  localparam int TACTL_ID_LSB  = 6;
  localparam int TACTL_MC_LSB  = 4;
  localparam int TACTL_CLR_BIT = 2;
  localparam int TACTL_IE_BIT  = 1;
  localparam int TACTL_IFG_BIT = 0;

  // TACCTL0 bit positions
  localparam int CCTL_IE_BIT  = 4;
  localparam int CCTL_IFG_BIT = 0;

  // Mode control encodings
  typedef enum logic [1:0] {
    MC_STOP   = 2'b00,
    MC_UP     = 2'b01,
    MC_CONT   = 2'b10,
    MC_UPDOWN = 2'b11
  } mc_e;

  // Up/down counting direction
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Register selected by the current bus address
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TACTL,
    SEL_TACCTL0,
    SEL_TAR,
    SEL_TACCR0
  } reg_sel_e;

  // Terminal prescaler count for input divider ID (div 1/2/4/8)
  function automatic logic [2:0] presc_last(input logic [1:0] id);
    case (id)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // Replace the enabled byte lanes of old_val with the matching lanes of lane_data
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                              input logic [1:0]  lane_we,
                                              input logic [15:0] lane_data);
    logic [15:0] res;
    res = old_val;
    for (int i = 0; i < 2; i++) begin
      if (lane_we[i]) res[8*i +: 8] = lane_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_a_periph_prescaler.sv
// Input-clock prescaler for the timer: a 3-bit counter that produces a
// one-cycle tick every 1/2/4/8 clocks while the timer is running.
module timer_a_periph_prescaler
  import timer_a_periph_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] id,
  input  mc_e        mc,
  input  logic       clr,
  output logic       tick
);

  logic [2:0] cnt_reg;
  logic [2:0] cnt_next;

  // Tick on the terminal count of the current divider, only while running
  assign tick = (mc != MC_STOP) && (cnt_reg == presc_last(id));

  // Counter advance: clear wins, stop freezes, terminal count wraps to zero
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = 3'd0;
    end else if (mc != MC_STOP) begin
      cnt_next = tick ? 3'd0 : cnt_reg + 3'd1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) cnt_reg <= 3'd0;
    else      cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/timer_a_periph.sv
// Timer_A-style memory-mapped peripheral: address decode, register bank,
// 16-bit counter with up / continuous / up-down modes, and registered IRQs.
module timer_a_periph
  import timer_a_periph_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0160,
  parameter int          SIZE      = 16
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     MAB_in,
  input  logic [SIZE-1:0] MDB_in,
  input  logic            MW,
  input  logic            BW,
  input  logic            irq_ack,
  output logic            per_hit,
  output logic [SIZE-1:0] per_dout,
  output logic            irq_ccr0,
  output logic            irq_ta
);

  // Register bank
  logic [1:0]      id_reg,    id_next;
  mc_e             mc_reg,    mc_next;
  logic            taie_reg,  taie_next;
  logic            taifg_reg, taifg_next;
  logic            ccie_reg,  ccie_next;
  logic            ccifg_reg, ccifg_next;
  dir_e            dir_reg,   dir_next;
  logic [SIZE-1:0] tar_reg,   tar_next;
  logic [SIZE-1:0] ccr0_reg,  ccr0_next;
  logic            irq_ccr0_reg;
  logic            irq_ta_reg;

  // Decode and write-path signals
  logic [15:0] word_offset;
  reg_sel_e    sel;
  logic [1:0]  lane_we;
  logic [15:0] lane_data;
  logic [7:0]  ctl_byte;
  logic        wr_en;
  logic        tactl_lo_wr;
  logic        tacctl_lo_wr;
  logic        tar_wr;
  logic        ccr0_wr;
  logic        taclr;
  logic        presc_clr;
  logic        tick;
  logic        ccr0_zero;
  logic        hw_taifg;
  logic        hw_ccifg;

  // Byte accesses hit the word register containing the addressed byte
  assign word_offset = {MAB_in[15:1], 1'b0} - BASE_ADDR;

  // Map the word offset onto one of the four registers
  always_comb begin
    case (word_offset)
      OFF_TACTL:   sel = SEL_TACTL;
      OFF_TACCTL0: sel = SEL_TACCTL0;
      OFF_TAR:     sel = SEL_TAR;
      OFF_TACCR0:  sel = SEL_TACCR0;
      default:     sel = SEL_NONE;
    endcase
  end

  assign per_hit = (sel != SEL_NONE);

  // Combinational read mux; unused bits and TACLR read as zero
  always_comb begin
    per_dout = '0;
    case (sel)
      SEL_TACTL: begin
        per_dout[TACTL_ID_LSB +: 2] = id_reg;
        per_dout[TACTL_MC_LSB +: 2] = mc_reg;
        per_dout[TACTL_IE_BIT]      = taie_reg;
        per_dout[TACTL_IFG_BIT]     = taifg_reg;
      end
      SEL_TACCTL0: begin
        per_dout[CCTL_IE_BIT]  = ccie_reg;
        per_dout[CCTL_IFG_BIT] = ccifg_reg;
      end
      SEL_TAR:    per_dout = tar_reg;
      SEL_TACCR0: per_dout = ccr0_reg;
      default:    per_dout = '0;
    endcase
  end

  // Byte-lane steering: a byte write carries its data in MDB_in[7:0] and
  // lands in the lane selected by the address LSB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_we[gi]          = !BW || (MAB_in[0] == 1'(gi));
    assign lane_data[8*gi +: 8] = BW ? MDB_in[7:0] : MDB_in[8*gi +: 8];
  end

  assign wr_en        = MW && per_hit;
  assign ctl_byte     = lane_data[7:0];
  // All control/status fields live in the low byte of their register
  assign tactl_lo_wr  = wr_en && (sel == SEL_TACTL)   && lane_we[0];
  assign tacctl_lo_wr = wr_en && (sel == SEL_TACCTL0) && lane_we[0];
  assign tar_wr       = wr_en && (sel == SEL_TAR);
  assign ccr0_wr      = wr_en && (sel == SEL_TACCR0);

  assign taclr = tactl_lo_wr && ctl_byte[TACTL_CLR_BIT];
  // The prescaler restarts when TACLR is written or a TACTL write changes ID
  assign presc_clr = taclr ||
                     (tactl_lo_wr && (ctl_byte[TACTL_ID_LSB +: 2] != id_reg));

  assign ccr0_zero = (ccr0_reg == '0);

  timer_a_periph_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .id   (id_reg),
    .mc   (mc_reg),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Counter/direction next state; TACLR beats a TAR write, which beats a tick
  always_comb begin
    tar_next = tar_reg;
    dir_next = dir_reg;
    hw_taifg = 1'b0;
    hw_ccifg = 1'b0;
    if (taclr) begin
      tar_next = '0;
      dir_next = DIR_UP;
    end else if (tar_wr) begin
      tar_next = merge_lanes(tar_reg, lane_we, lane_data);
    end else if (tick) begin
      case (mc_reg)
        MC_UP: begin
          if (ccr0_zero) begin
            tar_next = '0;
          end else if (tar_reg >= ccr0_reg) begin
            tar_next = '0;
            hw_taifg = 1'b1;
          end else begin
            tar_next = tar_reg + SIZE'(1);
          end
        end
        MC_CONT: begin
          tar_next = tar_reg + SIZE'(1);
          hw_taifg = (tar_reg == '1);
        end
        MC_UPDOWN: begin
          if (ccr0_zero) begin
            tar_next = '0;
            dir_next = DIR_UP;
          end else if (dir_reg == DIR_UP) begin
            if (tar_reg >= ccr0_reg) begin
              tar_next = tar_reg - SIZE'(1);
              dir_next = DIR_DOWN;
            end else begin
              tar_next = tar_reg + SIZE'(1);
            end
          end else begin
            if (tar_reg == SIZE'(1)) begin
              tar_next = '0;
              dir_next = DIR_UP;
              hw_taifg = 1'b1;
            end else if (tar_reg == '0) begin
              // Down at zero (only after a TAR write) bounces back upward
              tar_next = SIZE'(1);
              dir_next = DIR_UP;
            end else begin
              tar_next = tar_reg - SIZE'(1);
            end
          end
        end
        default: tar_next = tar_reg;
      endcase
      // Compare match on the new count; a zero CCR0 parks up/up-down silently
      hw_ccifg = (tar_next == ccr0_reg) && !(ccr0_zero && (mc_reg != MC_CONT));
    end
  end

  // Control/status next state: software write, then irq_ack, then hardware set
  always_comb begin
    id_next    = id_reg;
    mc_next    = mc_reg;
    taie_next  = taie_reg;
    taifg_next = taifg_reg;
    ccie_next  = ccie_reg;
    ccifg_next = ccifg_reg;
    ccr0_next  = ccr0_reg;
    if (tactl_lo_wr) begin
      id_next    = ctl_byte[TACTL_ID_LSB +: 2];
      mc_next    = mc_e'(ctl_byte[TACTL_MC_LSB +: 2]);
      taie_next  = ctl_byte[TACTL_IE_BIT];
      taifg_next = ctl_byte[TACTL_IFG_BIT];
    end
    if (hw_taifg) taifg_next = 1'b1;
    if (tacctl_lo_wr) begin
      ccie_next  = ctl_byte[CCTL_IE_BIT];
      ccifg_next = ctl_byte[CCTL_IFG_BIT];
    end
    if (irq_ack)  ccifg_next = 1'b0;
    if (hw_ccifg) ccifg_next = 1'b1;
    if (ccr0_wr)  ccr0_next  = merge_lanes(ccr0_reg, lane_we, lane_data);
  end

  // Register bank update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_reg    <= 2'd0;
      mc_reg    <= MC_STOP;
      taie_reg  <= 1'b0;
      taifg_reg <= 1'b0;
      ccie_reg  <= 1'b0;
      ccifg_reg <= 1'b0;
      dir_reg   <= DIR_UP;
      tar_reg   <= '0;
      ccr0_reg  <= '0;
    end else begin
      id_reg    <= id_next;
      mc_reg    <= mc_next;
      taie_reg  <= taie_next;
      taifg_reg <= taifg_next;
      ccie_reg  <= ccie_next;
      ccifg_reg <= ccifg_next;
      dir_reg   <= dir_next;
      tar_reg   <= tar_next;
      ccr0_reg  <= ccr0_next;
    end
  end

  // Interrupt requests follow the enable/flag pairs one cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_ccr0_reg <= 1'b0;
      irq_ta_reg   <= 1'b0;
    end else begin
      irq_ccr0_reg <= ccie_reg && ccifg_reg;
      irq_ta_reg   <= taie_reg && taifg_reg;
    end
  end

  assign irq_ccr0 = irq_ccr0_reg;
  assign irq_ta   = irq_ta_reg;

endmodule

// File: tb/tb_timer_a_periph.sv
// Self-checking bench for timer_a_periph: directed scenarios with literal
// expectations, then randomized bus traffic against a behavioural model.
module tb_timer_a_periph;

  localparam logic [15:0] BASE   = 16'h0160;
  localparam logic [15:0] A_CTL  = BASE;
  localparam logic [15:0] A_CCTL = BASE + 16'h0002;
  localparam logic [15:0] A_TAR  = BASE + 16'h0010;
  localparam logic [15:0] A_CCR  = BASE + 16'h0012;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] MAB_in = 16'h0000;
  logic [15:0] MDB_in = 16'h0000;
  logic        MW = 1'b0;
  logic        BW = 1'b0;
  logic        irq_ack = 1'b0;
  logic        per_hit;
  logic [15:0] per_dout;
  logic        irq_ccr0;
  logic        irq_ta;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  timer_a_periph #(.BASE_ADDR(BASE), .SIZE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .MAB_in   (MAB_in),
    .MDB_in   (MDB_in),
    .MW       (MW),
    .BW       (BW),
    .irq_ack  (irq_ack),
    .per_hit  (per_hit),
    .per_dout (per_dout),
    .irq_ccr0 (irq_ccr0),
    .irq_ta   (irq_ta)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_tar, m_ccr0, m_id, m_mc, m_pcnt;
  bit m_taie, m_taifg, m_ccie, m_ccifg, m_down, m_irq_ccr0, m_irq_ta;

  function automatic int m_regidx(input logic [15:0] a);
    int off;
    off = int'({a[15:1], 1'b0}) - int'(BASE);
    if (off == 0)     return 0;
    if (off == 2)     return 1;
    if (off == 'h10)  return 2;
    if (off == 'h12)  return 3;
    return -1;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (m_regidx(a))
      0:       return 16'(m_id * 64 + m_mc * 16 + int'(m_taie) * 2 + int'(m_taifg));
      1:       return 16'(int'(m_ccie) * 16 + int'(m_ccifg));
      2:       return 16'(m_tar);
      3:       return 16'(m_ccr0);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    int idx, cur, wd, n_tar, div;
    bit wr, tick, taclr, pclr, set_ta, set_cc, n_down;
    if (!rst) begin
      m_tar = 0; m_ccr0 = 0; m_id = 0; m_mc = 0; m_pcnt = 0;
      m_taie = 0; m_taifg = 0; m_ccie = 0; m_ccifg = 0; m_down = 0;
      m_irq_ccr0 = 0; m_irq_ta = 0;
    end else begin
      m_irq_ccr0 = m_ccie & m_ccifg;
      m_irq_ta   = m_taie & m_taifg;
      idx = m_regidx(MAB_in);
      wr  = MW && (idx >= 0);
      cur = int'(m_read(MAB_in));
      if (!BW)            wd = int'(MDB_in);
      else if (MAB_in[0]) wd = int'(MDB_in[7:0]) * 256 + (cur % 256);
      else                wd = (cur / 256) * 256 + int'(MDB_in[7:0]);
      div   = 1 << m_id;
      tick  = (m_mc != 0) && (m_pcnt == div - 1);
      taclr = wr && (idx == 0) && wd[2];
      pclr  = taclr || (wr && (idx == 0) && (int'(wd[7:6]) != m_id));
      n_tar = m_tar; n_down = m_down; set_ta = 0; set_cc = 0;
      if (taclr) begin
        n_tar = 0; n_down = 0;
      end else if (wr && idx == 2) begin
        n_tar = wd;
      end else if (tick) begin
        case (m_mc)
          1: begin
            if (m_ccr0 == 0) n_tar = 0;
            else if (m_tar >= m_ccr0) begin n_tar = 0; set_ta = 1; end
            else n_tar = m_tar + 1;
          end
          2: begin
            n_tar = (m_tar + 1) % 65536;
            set_ta = (m_tar == 65535);
          end
          default: begin
            if (m_ccr0 == 0) begin n_tar = 0; n_down = 0; end
            else if (!m_down) begin
              if (m_tar >= m_ccr0) begin n_tar = m_tar - 1; n_down = 1; end
              else n_tar = m_tar + 1;
            end else if (m_tar == 1) begin n_tar = 0; n_down = 0; set_ta = 1; end
            else if (m_tar == 0) begin n_tar = 1; n_down = 0; end
            else n_tar = m_tar - 1;
          end
        endcase
        set_cc = (n_tar == m_ccr0) && !(m_ccr0 == 0 && m_mc != 2);
      end
      if (pclr) m_pcnt = 0;
      else if (m_mc != 0) m_pcnt = tick ? 0 : m_pcnt + 1;
      m_tar = n_tar; m_down = n_down;
      if (wr && idx == 0) begin
        m_id = int'(wd[7:6]); m_mc = int'(wd[5:4]);
        m_taie = wd[1]; m_taifg = wd[0];
      end
      if (set_ta) m_taifg = 1;
      if (wr && idx == 1) begin m_ccie = wd[4]; m_ccifg = wd[0]; end
      if (irq_ack) m_ccifg = 0;
      if (set_cc)  m_ccifg = 1;
      if (wr && idx == 3) m_ccr0 = wd;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_per_hit",  16'(per_hit),  16'(m_regidx(MAB_in) >= 0));
      chk("model_per_dout", per_dout,      m_read(MAB_in));
      chk("model_irq_ccr0", 16'(irq_ccr0), 16'(m_irq_ccr0));
      chk("model_irq_ta",   16'(irq_ta),   16'(m_irq_ta));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic b);
    MAB_in = a; MDB_in = d; BW = b; MW = 1'b1;
    step();
    MW = 1'b0; BW = 1'b0;
  endtask

  task automatic chk_rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    MAB_in = a; MW = 1'b0;
    #1;
    chk(name, per_dout, exp);
  endtask

  initial begin
    logic [15:0] d;
    // 1. Reset held two cycles with write pulses
    rst = 1'b0;
    repeat (2) begin
      MAB_in = A_CTL; MDB_in = 16'h00F7; MW = 1'b1;
      step();
    end
    MW = 1'b0;
    chk_en = 1'b1;
    chk_rd(A_CTL,  16'h0000, "rst_tactl");
    chk_rd(A_CCTL, 16'h0000, "rst_tacctl0");
    chk_rd(A_TAR,  16'h0000, "rst_tar");
    chk("rst_irq_ccr0", 16'(irq_ccr0), 16'h0000);
    chk("rst_irq_ta",   16'(irq_ta),   16'h0000);
    chk_rd(A_CCR,  16'h0000, "rst_taccr0");
    rst = 1'b1;
    step();

    // 2. Up mode, ID=00, CCR0=3
    wr(A_CCR, 16'h0003, 1'b0);
    wr(A_CTL, 16'h0012, 1'b0);
    chk_rd(A_TAR, 16'h0000, "up_tar0");
    step(); chk_rd(A_TAR, 16'h0001, "up_tar1");
    step(); chk_rd(A_TAR, 16'h0002, "up_tar2");
    step(); chk_rd(A_TAR, 16'h0003, "up_tar3");
    chk_rd(A_CCTL, 16'h0001, "up_ccifg");
    chk_rd(A_CTL, 16'h0012, "up_no_taifg");
    step(); chk_rd(A_TAR, 16'h0000, "up_wrap");
    chk_rd(A_CTL, 16'h0013, "up_taifg");
    chk("up_irq_ta_lag", 16'(irq_ta), 16'h0000);
    step(); chk("up_irq_ta", 16'(irq_ta), 16'h0001);
    chk_rd(A_TAR, 16'h0001, "up_tar_again");

    // 3. Continuous mode, ID=11 (divide by 8)
    wr(A_CTL, 16'h0000, 1'b0);
    wr(A_CCTL, 16'h0000, 1'b0);
    wr(A_TAR, 16'hFFFE, 1'b0);
    wr(A_CTL, 16'h00E0, 1'b0);
    chk_rd(A_TAR, 16'hFFFE, "cont_start");
    repeat (7) step();
    chk_rd(A_TAR, 16'hFFFE, "cont_hold7");
    step(); chk_rd(A_TAR, 16'hFFFF, "cont_ffff");
    repeat (7) step();
    chk_rd(A_TAR, 16'hFFFF, "cont_hold_ffff");
    step(); chk_rd(A_TAR, 16'h0000, "cont_wrap");
    chk_rd(A_CTL, 16'h00E1, "cont_taifg");

    // 4. Up/down, CCR0=2
    wr(A_CTL, 16'h0004, 1'b0);
    chk_rd(A_TAR, 16'h0000, "taclr_tar");
    wr(A_CCR, 16'h0002, 1'b0);
    wr(A_CCTL, 16'h0000, 1'b0);
    wr(A_CTL, 16'h0030, 1'b0);
    chk_rd(A_TAR, 16'h0000, "ud_tar0");
    step(); chk_rd(A_TAR, 16'h0001, "ud_tar1");
    step(); chk_rd(A_TAR, 16'h0002, "ud_tar2");
    chk_rd(A_CCTL, 16'h0001, "ud_ccifg");
    step(); chk_rd(A_TAR, 16'h0001, "ud_tar1_down");
    chk_rd(A_CTL, 16'h0030, "ud_no_taifg");
    step(); chk_rd(A_TAR, 16'h0000, "ud_tar0_down");
    chk_rd(A_CTL, 16'h0031, "ud_taifg");
    step(); chk_rd(A_TAR, 16'h0001, "ud_tar1_up");

    // 5. Conflicts
    wr(A_TAR, 16'h1234, 1'b0);
    chk_rd(A_TAR, 16'h1234, "conf_tar_write");
    wr(A_CTL, 16'h0000, 1'b0);
    wr(A_CCR, 16'h0003, 1'b0);
    wr(A_TAR, 16'h0003, 1'b0);
    wr(A_CTL, 16'h0010, 1'b0);
    wr(A_CTL, 16'h0010, 1'b0);
    chk_rd(A_CTL, 16'h0011, "conf_taifg_hw_wins");
    chk_rd(A_TAR, 16'h0000, "conf_tar_wrap");
    wr(A_CCTL, 16'h0000, 1'b0);
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk_rd(A_TAR, 16'h0003, "conf_tar3");
    chk_rd(A_CCTL, 16'h0001, "conf_ccifg_hw_wins");
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk_rd(A_CCTL, 16'h0000, "ack_clears_ccifg");

    // 6. Byte writes and non-hit addresses
    wr(A_CTL, 16'h0000, 1'b0);
    wr(A_CCR, 16'h1111, 1'b0);
    wr(BASE + 16'h0013, 16'h00AB, 1'b1);
    chk_rd(A_CCR, 16'hAB11, "byte_hi");
    wr(BASE + 16'h0012, 16'h55CD, 1'b1);
    chk_rd(A_CCR, 16'hABCD, "byte_lo");
    chk_rd(16'h0200, 16'h0000, "nohit_dout");
    chk("nohit_hit", 16'(per_hit), 16'h0000);
    chk_rd(BASE + 16'h0004, 16'h0000, "nohit_gap_dout");
    chk("nohit_gap_hit", 16'(per_hit), 16'h0000);

    // 7. Randomized traffic checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) != 0);
      irq_ack = ($urandom_range(0, 7) == 0);
      MW      = ($urandom_range(0, 3) == 0);
      BW      = ($urandom_range(0, 4) == 0);
      d       = 16'($urandom);
      case ($urandom_range(0, 9))
        0: begin
          MAB_in = A_CTL;
          d[5:4] = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
          d[7:6] = 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
          d[2]   = ($urandom_range(0, 7) == 0);
        end
        1: MAB_in = A_CCTL;
        2: begin MAB_in = A_CCR; d = 16'($urandom_range(0, 12)); end
        3: begin MAB_in = A_TAR; d = 16'($urandom_range(0, 14)); end
        4: MAB_in = 16'($urandom);
        default: MAB_in = A_TAR;
      endcase
      if ($urandom_range(0, 5) == 0) MAB_in[0] = 1'b1;
      MDB_in = d;
      step();
    end
    rst = 1'b1; MW = 1'b0; irq_ack = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
